// File: rtl/hs_slice_pkg.sv
// Shared definitions for the handshake register slice: the per-stage state
// encoding and the helpers that size and fill the occupancy counter.
package hs_slice_pkg;

    // A stage holds zero, one (main) or two (main + skid) words.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_e;

    // Bits needed to count 0..2*stages words; never narrower than one bit.
    function automatic int level_width(input int stages);
        int w;
        w = $clog2(2 * stages + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

    // Number of words a stage holds in a given state.
    function automatic logic [1:0] state_entries(input stage_state_e st);
        case (st)
            ST_ONE:  return 2'd1;
            ST_TWO:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/hs_slice_stage.sv
// One two-entry skid buffer. The main register drives the output; the skid
// register catches the word that arrives while the output is stalled, so the
// upstream ready can be a flop instead of a combinational copy of m_ready.
module hs_slice_stage
    import hs_slice_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [1:0]       entries_nx
);

    stage_state_e     state_q;
    stage_state_e     state_d;
    logic             ready_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    logic in_xfer;
    logic out_xfer;
    logic load_main;
    logic load_skid;
    logic skid_to_main;

    assign in_xfer    = s_valid & ready_q;
    assign out_xfer   = m_valid & m_ready;
    assign s_ready    = ready_q;
    assign m_data     = main_q;
    assign entries_nx = state_entries(state_d);

    // State and registered ready; ready is low in reset and only rises on
    // the first edge after release, and otherwise tracks "not full next".
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != ST_TWO);
        end
    end

    // Next state from which of the two ports transfer this cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_xfer && !out_xfer) begin
                    state_d = ST_TWO;
                end else if (!in_xfer && out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_xfer) begin
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Output valid and the datapath load enables decoded from the state.
    always_comb begin
        m_valid      = (state_q != ST_EMPTY);
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                load_main = in_xfer;
            end
            ST_ONE: begin
                load_main = in_xfer & out_xfer;
                load_skid = in_xfer & ~out_xfer;
            end
            ST_TWO: begin
                skid_to_main = out_xfer;
            end
            default: begin
                load_main = 1'b0;
            end
        endcase
    end

    // Payload registers; cleared in reset so nothing stale can reappear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main) begin
                main_q <= s_data;
            end else if (skid_to_main) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= s_data;
            end
        end
    end

endmodule

// File: rtl/hs_reg_slice.sv
// Valid/ready register slice built from a chain of skid-buffer stages.
// STAGE=0 degenerates to wires; otherwise every stage breaks both the
// forward (valid/data) and the backward (ready) timing path.
module hs_reg_slice
    import hs_slice_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int STAGE = 1,
    localparam int LW    = level_width(STAGE)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [LW-1:0]    level
);

    if (STAGE == 0) begin : g_bypass

        assign m_valid = s_valid;
        assign m_data  = s_data;
        assign s_ready = m_ready;
        assign level   = '0;

    end else begin : g_chain

        logic             vld [0:STAGE];
        logic             rdy [0:STAGE];
        logic [WIDTH-1:0] dat [0:STAGE];
        logic [1:0]       entries_nx [0:STAGE-1];
        logic [LW-1:0]    level_d;
        logic [LW-1:0]    level_q;

        assign vld[0]     = s_valid;
        assign dat[0]     = s_data;
        assign s_ready    = rdy[0];
        assign m_valid    = vld[STAGE];
        assign m_data     = dat[STAGE];
        assign rdy[STAGE] = m_ready;
        assign level      = level_q;

        for (genvar k = 0; k < STAGE; k++) begin : g_stage
            hs_slice_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk_i      (clk_i),
                .rst_ni     (rst_ni),
                .s_valid    (vld[k]),
                .s_ready    (rdy[k]),
                .s_data     (dat[k]),
                .m_valid    (vld[k+1]),
                .m_ready    (rdy[k+1]),
                .m_data     (dat[k+1]),
                .entries_nx (entries_nx[k])
            );
        end

        // Sum of every stage's occupancy after this edge; bounded by 2*STAGE.
        always_comb begin
            level_d = '0;
            for (int k = 0; k < STAGE; k++) begin
                level_d = level_d + LW'(entries_nx[k]);
            end
        end

        // Registered occupancy so level lines up with the stage states.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                level_q <= '0;
            end else begin
                level_q <= level_d;
            end
        end

    end

endmodule
